rf_wb_sched: RTL and testbench

- Writeback scheduler for the single-write-port register file.
- Shares the one write port between NREQ writeback requesters (ALU, load unit, ...) using round-robin arbitration with a valid/ready handshake.
- Drives the register file's global write enable, one-hot write enables and write data from a registered stage.
- Keeps a pending-write scoreboard (busy bit per register) so the issue stage can stall on registers that are not yet written.

---
 rtl/rf_wb_sched_pkg.sv | 15 +
 rtl/rf_wb_sched_rr_arbiter.sv | 29 ++
 rtl/rf_wb_sched.sv | 106 ++++++++++
 tb/tb_rf_wb_sched.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_wb_sched_pkg.sv
// Shared configuration for the register-file writeback scheduler.
// Register geometry normally arrives from config.v; these defaults cover standalone builds.
`ifndef RW
`define RW 16
`endif
`ifndef REGNO
`define REGNO 8
`endif
`ifndef REGNO_LOG
`define REGNO_LOG 3
`endif

package rf_wb_sched_pkg;
  localparam int WB_NREQ = 2;
endpackage

// File: rtl/rf_wb_sched_rr_arbiter.sv
// Round-robin arbiter: grants the first valid requester at or after the pointer.
module rr_arbiter
  import rf_wb_sched_pkg::*;
#(
  parameter int NREQ = WB_NREQ,
  parameter int PW   = 1
) (
  input  logic [NREQ-1:0] i_valid,
  input  logic [PW-1:0]   i_ptr,
  output logic [NREQ-1:0] o_grant
);

  logic found;

  always_comb begin
    o_grant = '0;
    found   = 1'b0;
    // Offset i walks the ring starting at the pointer; j keeps every index constant.
    for (int i = 0; i < NREQ; i++) begin
      for (int j = 0; j < NREQ; j++) begin
        if (!found && (j == (int'(i_ptr) + i) % NREQ) && i_valid[j]) begin
          o_grant[j] = 1'b1;
          found      = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/rf_wb_sched.sv
// Writeback scheduler: round-robin shares the single register-file write port and
// tracks outstanding writes in a busy-bit scoreboard for the issue stage.
module rf_wb_sched
  import rf_wb_sched_pkg::*;
#(
  parameter int NREQ      = WB_NREQ,
  parameter int RW        = `RW,
  parameter int REGNO     = `REGNO,
  parameter int REGNO_LOG = `REGNO_LOG
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [NREQ-1:0]           i_req_valid,
  input  logic [NREQ*REGNO_LOG-1:0] i_req_sel,
  input  logic [NREQ*RW-1:0]        i_req_data,
  output logic [NREQ-1:0]           o_req_ready,
  input  logic                      i_rsv_valid,
  input  logic [REGNO_LOG-1:0]      i_rsv_sel,
  input  logic                      i_flush,
  output logic [REGNO-1:0]          o_busy,
  output logic                      o_gie,
  output logic [REGNO-1:0]          o_ie,
  output logic [RW-1:0]             o_d
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0]        ptr_q, ptr_d;
  logic                 gie_q, gie_d;
  logic [REGNO-1:0]     ie_q, ie_d;
  logic [REGNO-1:0]     busy_q, busy_d;
  logic [RW-1:0]        d_q, d_d;
  logic [NREQ-1:0]      vld_eff, grant;
  logic                 acc;
  logic [PW-1:0]        idx_g;
  logic [REGNO_LOG-1:0] sel_g;
  logic [RW-1:0]        data_g;

  // Out-of-range selects decode to all-zero, so such writes change no register.
  function automatic logic [REGNO-1:0] dec_sel(input logic [REGNO_LOG-1:0] s);
    dec_sel = '0;
    for (int r = 0; r < REGNO; r++) begin
      if (s == REGNO_LOG'(r)) dec_sel[r] = 1'b1;
    end
  endfunction

  assign vld_eff = i_req_valid & {NREQ{~(i_flush | i_rst)}};

  rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_arb (
    .i_valid (vld_eff),
    .i_ptr   (ptr_q),
    .o_grant (grant)
  );

  assign o_req_ready = grant;

  always_comb begin
    acc    = 1'b0;
    idx_g  = '0;
    sel_g  = '0;
    data_g = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (grant[k]) begin
        acc    = 1'b1;
        idx_g  = PW'(k);
        sel_g  = i_req_sel[k*REGNO_LOG +: REGNO_LOG];
        data_g = i_req_data[k*RW +: RW];
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (acc) ptr_d = (idx_g == PW'(NREQ-1)) ? '0 : idx_g + PW'(1);
    gie_d = acc;
    ie_d  = acc ? dec_sel(sel_g) : '0;
    d_d   = acc ? data_g : d_q;
    // Clear first so a same-edge reservation of the written register wins.
    busy_d = busy_q;
    if (gie_q) busy_d = busy_d & ~ie_q;
    if (i_rsv_valid) busy_d = busy_d | dec_sel(i_rsv_sel);
    if (i_flush) busy_d = '0;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ptr_q  <= '0;
      gie_q  <= 1'b0;
      ie_q   <= '0;
      busy_q <= '0;
      d_q    <= '0;
    end else begin
      ptr_q  <= ptr_d;
      gie_q  <= gie_d;
      ie_q   <= ie_d;
      busy_q <= busy_d;
      d_q    <= d_d;
    end
  end

  assign o_gie  = gie_q;
  assign o_ie   = ie_q;
  assign o_d    = d_q;
  assign o_busy = busy_q;

endmodule

// File: tb/tb_rf_wb_sched.sv
// Self-checking bench for rf_wb_sched: directed scenarios plus randomized traffic
// compared each cycle against a behavioural model of grants, writes and busy bits.
module tb_rf_wb_sched;

  localparam int NREQ = 2;
  localparam int RW   = 16;
  localparam int REGNO = 8;
  localparam int LOG  = 3;

  logic                 i_clk;
  logic                 i_rst;
  logic [NREQ-1:0]      i_req_valid;
  logic [NREQ*LOG-1:0]  i_req_sel;
  logic [NREQ*RW-1:0]   i_req_data;
  logic [NREQ-1:0]      o_req_ready;
  logic                 i_rsv_valid;
  logic [LOG-1:0]       i_rsv_sel;
  logic                 i_flush;
  logic [REGNO-1:0]     o_busy;
  logic                 o_gie;
  logic [REGNO-1:0]     o_ie;
  logic [RW-1:0]        o_d;

  rf_wb_sched #(.NREQ(NREQ), .RW(RW), .REGNO(REGNO), .REGNO_LOG(LOG)) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_req_valid (i_req_valid),
    .i_req_sel   (i_req_sel),
    .i_req_data  (i_req_data),
    .o_req_ready (o_req_ready),
    .i_rsv_valid (i_rsv_valid),
    .i_rsv_sel   (i_rsv_sel),
    .i_flush     (i_flush),
    .o_busy      (o_busy),
    .o_gie       (o_gie),
    .o_ie        (o_ie),
    .o_d         (o_d)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Requester-side stimulus state
  logic           rv [NREQ];
  logic [LOG-1:0] rs [NREQ];
  logic [RW-1:0]  rd [NREQ];
  logic           rsv_v;
  logic [LOG-1:0] rsv_s;
  logic           flush;

  // Behavioural model
  int             m_ptr;
  bit             m_gie;
  int             m_reg;
  logic [RW-1:0]  m_d;
  logic [REGNO-1:0] m_busy;
  int             last_g;

  int passed = 0;
  int total  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic apply();
    for (int k = 0; k < NREQ; k++) begin
      i_req_valid[k]           = rv[k];
      i_req_sel[k*LOG +: LOG]  = rs[k];
      i_req_data[k*RW +: RW]   = rd[k];
    end
    i_rsv_valid = rsv_v;
    i_rsv_sel   = rsv_s;
    i_flush     = flush;
  endtask

  task automatic model_reset();
    m_ptr = 0; m_gie = 0; m_reg = 0; m_d = '0; m_busy = '0; last_g = -1;
  endtask

  // First valid requester at or after the pointer, none during flush or reset.
  function automatic int m_pick();
    if (flush || i_rst) return -1;
    for (int i = 0; i < NREQ; i++) begin
      if (rv[(m_ptr + i) % NREQ]) return (m_ptr + i) % NREQ;
    end
    return -1;
  endfunction

  function automatic logic [REGNO-1:0] m_ie();
    logic [REGNO-1:0] v;
    v = '0;
    if (m_gie && m_reg < REGNO) v[m_reg] = 1'b1;
    return v;
  endfunction

  task automatic model_edge();
    int g;
    g = m_pick();
    if (m_gie && m_reg < REGNO) m_busy[m_reg] = 1'b0;
    if (rsv_v) m_busy[rsv_s] = 1'b1;
    if (flush) m_busy = '0;
    if (g >= 0) begin
      m_gie = 1; m_reg = int'(rs[g]); m_d = rd[g]; m_ptr = (g + 1) % NREQ;
    end else begin
      m_gie = 0;
    end
    last_g = g;
  endtask

  task automatic compare_all();
    logic [NREQ-1:0] er;
    int g;
    er = '0;
    g = m_pick();
    if (g >= 0) er[g] = 1'b1;
    chk("ready", o_req_ready, er);
    chk("gie", o_gie, m_gie);
    chk("ie", o_ie, m_ie());
    chk("d", o_d, m_d);
    chk("busy", o_busy, m_busy);
  endtask

  // Called at a negedge with stimulus set; returns at the next negedge.
  task automatic tick();
    apply();
    #1;
    compare_all();
    @(posedge i_clk);
    model_edge();
    @(negedge i_clk);
  endtask

  int cnt0, cnt1;

  initial begin
    for (int k = 0; k < NREQ; k++) begin rv[k] = 0; rs[k] = '0; rd[k] = '0; end
    rsv_v = 0; rsv_s = '0; flush = 0;
    i_req_valid = '0; i_req_sel = '0; i_req_data = '0;
    i_rsv_valid = 0; i_rsv_sel = '0; i_flush = 0;
    model_reset();

    // Reset state; a valid request must not see ready while reset is held
    i_rst = 1'b1;
    rv[0] = 1;
    apply();
    #12;
    chk("rst_gie", o_gie, 1'b0);
    chk("rst_ie", o_ie, 8'h00);
    chk("rst_d", o_d, 16'h0000);
    chk("rst_busy", o_busy, 8'h00);
    chk("rst_ready", o_req_ready, 2'b00);
    @(negedge i_clk);
    rv[0] = 0;
    i_rst = 1'b0;
    apply();

    // Single write
    rv[0] = 1; rs[0] = 3'd3; rd[0] = 16'hBEEF;
    apply(); #1;
    chk("single_ready", o_req_ready, 2'b01);
    tick(); rv[0] = 0;
    chk("single_gie", o_gie, 1'b1);
    chk("single_ie", o_ie, 8'b0000_1000);
    chk("single_d", o_d, 16'hBEEF);
    tick();
    chk("single_gie_drop", o_gie, 1'b0);

    // Bring the pointer back to 0 with a write from requester 1
    rv[1] = 1; rs[1] = 3'd0; rd[1] = 16'h0000;
    tick(); rv[1] = 0;
    tick();

    // Contention
    rv[0] = 1; rs[0] = 3'd1; rd[0] = 16'h0001;
    rv[1] = 1; rs[1] = 3'd2; rd[1] = 16'h0002;
    apply(); #1;
    chk("cont_ready0", o_req_ready, 2'b01);
    tick(); rv[0] = 0;
    chk("cont_ie0", o_ie, 8'h02);
    apply(); #1;
    chk("cont_ready1", o_req_ready, 2'b10);
    tick(); rv[1] = 0;
    chk("cont_ie1", o_ie, 8'h04);
    chk("cont_d1", o_d, 16'h0002);

    // Fairness: both valid for 8 cycles, new payload after each grant
    cnt0 = 0; cnt1 = 0;
    rv[0] = 1; rv[1] = 1;
    for (int c = 0; c < 8; c++) begin
      apply(); #1;
      chk("fair_alt", o_req_ready, (c % 2 == 0) ? 2'b01 : 2'b10);
      if (o_req_ready[0]) cnt0++;
      if (o_req_ready[1]) cnt1++;
      tick();
      if (last_g >= 0) begin
        rs[last_g] = LOG'($urandom_range(0, REGNO-1));
        rd[last_g] = RW'($urandom);
      end
    end
    chk("fair_cnt0", cnt0, 4);
    chk("fair_cnt1", cnt1, 4);
    rv[0] = 0; rv[1] = 0;
    tick();

    // Scoreboard: reserve r5, write it, re-reserve on the clearing edge
    rsv_v = 1; rsv_s = 3'd5;
    tick(); rsv_v = 0;
    chk("sb_set", o_busy[5], 1'b1);
    tick(); tick();
    rv[1] = 1; rs[1] = 3'd5; rd[1] = 16'h5555;
    tick(); rv[1] = 0;
    chk("sb_write_gie", o_gie, 1'b1);
    chk("sb_still_busy", o_busy[5], 1'b1);
    rsv_v = 1; rsv_s = 3'd5;
    tick(); rsv_v = 0;
    chk("sb_set_wins", o_busy[5], 1'b1);
    rv[0] = 1; rs[0] = 3'd5; rd[0] = 16'h6666;
    tick(); rv[0] = 0;
    tick();
    chk("sb_clear", o_busy[5], 1'b0);

    // Flush with an in-flight write
    rsv_v = 1; rsv_s = 3'd2;
    tick();
    rsv_s = 3'd6;
    rv[0] = 1; rs[0] = 3'd7; rd[0] = 16'h7777;
    tick(); rsv_v = 0; rv[0] = 0;
    chk("fl_busy_pre", o_busy, 8'h44);
    flush = 1;
    rv[0] = 1; rs[0] = 3'd0; rd[0] = 16'h0F0F;
    apply(); #1;
    chk("fl_ready", o_req_ready, 2'b00);
    chk("fl_inflight_gie", o_gie, 1'b1);
    chk("fl_inflight_ie", o_ie, 8'h80);
    tick(); flush = 0;
    chk("fl_busy", o_busy, 8'h00);
    chk("fl_gie_after", o_gie, 1'b0);
    tick(); rv[0] = 0;
    chk("fl_late_d", o_d, 16'h0F0F);

    // Asynchronous reset while a write is in the write stage
    rsv_v = 1; rsv_s = 3'd1;
    rv[0] = 1; rs[0] = 3'd3; rd[0] = 16'h1234;
    tick(); rsv_v = 0; rv[0] = 0;
    chk("ar_gie_pre", o_gie, 1'b1);
    rv[1] = 1; rs[1] = 3'd4; rd[1] = 16'h4444;
    apply();
    #2 i_rst = 1'b1;
    #1;
    chk("ar_gie", o_gie, 1'b0);
    chk("ar_ie", o_ie, 8'h00);
    chk("ar_busy", o_busy, 8'h00);
    chk("ar_ready", o_req_ready, 2'b00);
    #1 i_rst = 1'b0;
    rv[1] = 0;
    apply();
    model_reset();
    @(negedge i_clk);

    // Randomized traffic honouring the hold-until-ready rule
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < NREQ; k++) begin
        if (!rv[k] && $urandom_range(0, 2) != 0) begin
          rv[k] = 1;
          rs[k] = LOG'($urandom_range(0, REGNO-1));
          rd[k] = RW'($urandom);
        end
      end
      rsv_v = ($urandom_range(0, 2) == 0);
      rsv_s = LOG'($urandom_range(0, REGNO-1));
      flush = ($urandom_range(0, 15) == 0);
      tick();
      if (last_g >= 0) rv[last_g] = 0;
    end
    rv[0] = 0; rv[1] = 0; rsv_v = 0; flush = 0;
    tick();
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
